coeff_vector_loader: RTL and testbench
======================================

Name: coeff_vector_loader

Overview:
- Upstream feeder for the circular-shift stage of the non-power-of-two NTT datapath.
- Accepts one WIDTH-bit coefficient per beat over a valid/ready stream and assembles SIZE coefficients into one SIZE*WIDTH-bit vector.
- Captures the frame's shift amount and presents vector plus shift to the shifter with a valid/ready handshake.
- Holds the vector stable until the shifter consumes it.

Parameters:
- WIDTH, 32, bits per coefficient
- SIZE, 257, coefficients per vector (lanes)
- SHIFT_W, 9, width of shift amount; must satisfy 2**SHIFT_W < 2*SIZE when SHIFT_REDUCE_EN is defined

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_data  input  WIDTH  incoming coefficient
- s_shift  input  SHIFT_W  shift amount; sampled only on the first beat of a frame
- s_last  input  1  marks final beat of a frame
- s_valid  input  1  beat valid
- s_ready  output  1  loader can accept a beat
- out_list  output  SIZE*WIDTH  assembled vector; lane i = bits [i*WIDTH +: WIDTH]
- out_shift  output  SHIFT_W  shift amount for out_list
- out_valid  output  1  out_list/out_shift valid
- out_ready  input  1  downstream consumes the vector
- err_len  output  1  sticky frame-length error

Behaviour:
- Reset (rst=1 at a clock edge) clears all state:
  - state=FILL, idx=0
  - out_list=0, out_shift=0, out_valid=0, err_len=0
- Reset overrides any in-flight frame or pending output; the partial frame is discarded.
- While rst is high, beats are ignored.
- s_ready = (state==FILL). It is combinational from state, with no dependence on s_valid.
- Beat accepted when s_valid && s_ready at a clock edge:
  - Lane idx is written with s_data.
  - If idx==0, out_shift is loaded from s_shift.
  - idx increments.
- Frame closes on the accepted beat where s_last=1 or idx==SIZE-1, whichever comes first:
  - Next cycle: state=FULL, out_valid=1, idx=0.
- Early s_last (idx<SIZE-1): frame closes; unwritten lanes stay 0; err_len set.
- Beat at idx==SIZE-1 with s_last=0: frame closes anyway; err_len set. The following beats form the next frame.
- FULL state:
  - s_ready=0.
  - out_list, out_shift and out_valid are held stable until out_ready=1.
- On out_valid && out_ready at a clock edge:
  - Next cycle: state=FILL, out_valid=0, out_list cleared to 0, s_ready=1.
  - out_shift holds its value until the next frame's first beat.
- Throughput: no overlap, no bypass. Minimum SIZE+1 cycles per vector; out_valid rises one cycle after the last beat.
- err_len is sticky until rst.
- Registered outputs: out_list, out_shift, out_valid, err_len.

Optional Feature:
- Macro: SHIFT_REDUCE_EN
- Defined: the shift captured on the first beat is reduced mod SIZE by a single conditional subtraction (s_shift>=SIZE -> s_shift-SIZE). Example, defaults: s_shift=300 -> out_shift=43. Capture latency is unchanged.
- Undefined: s_shift is stored unmodified. The downstream shifter receives values >= SIZE as-is.

Test Plan:
- Reset, then stream 257 beats with data=i+1, shift=5 on beat 0, s_last on beat 256 -> out_valid one cycle after beat 256; lane i = i+1; out_shift=5; err_len=0; s_ready=0 while FULL.
- Hold out_ready=0 for 20 cycles, then pulse out_ready=1 for 1 cycle -> out_list/out_shift stable for all 20 cycles; out_valid=0 and s_ready=1 the next cycle; out_list=0.
- SIZE=5 build, frame with s_last on beat 2 (data 7,8,9) -> lanes {7,8,9,0,0}; out_valid=1; err_len=1, still 1 after a subsequent clean frame.
- SIZE=5 build, 6 beats, no s_last -> first vector = beats 0-4 with err_len=1; beat 5 becomes lane 0 of the next frame.
- Assert rst during beat 100 of a frame -> out_valid=0, out_list=0, err_len=0; the next frame's beat 0 lands in lane 0.
- SHIFT_REDUCE_EN: first-beat shift 300 -> out_shift=43. Shift 256 -> 256 in both builds. Without the macro, shift 300 -> out_shift=300.

Source files
------------

// File: rtl/coeff_vector_loader.sv
// Assembles SIZE streamed WIDTH-bit coefficients plus a per-frame shift into one vector for the shifter.
// Optional macro SHIFT_REDUCE_EN: reduce the captured shift mod SIZE with one conditional subtraction.
module coeff_vector_loader #(
  parameter int WIDTH   = 32,
  parameter int SIZE    = 257,
  parameter int SHIFT_W = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        s_data,
  input  logic [SHIFT_W-1:0]      s_shift,
  input  logic                    s_last,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [SIZE*WIDTH-1:0]   out_list,
  output logic [SHIFT_W-1:0]      out_shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_len
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic {FILL, FULL} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [SHIFT_W-1:0] shift_reg;
  logic               valid_reg;
  logic               err_reg;

  logic               accept;
  logic               last_lane;
  logic               consume;
  logic [SHIFT_W-1:0] shift_in;

  assign s_ready   = (state_reg == FILL);
  assign accept    = s_valid && (state_reg == FILL);
  assign last_lane = (idx_reg == IDX_W'(SIZE - 1));
  assign consume   = valid_reg && out_ready;

`ifdef SHIFT_REDUCE_EN
  // When SIZE does not fit in SHIFT_W bits no stored value can reach it, so no reduction is needed.
  localparam int unsigned SHIFT_SPAN = 2 ** SHIFT_W;
  localparam bit          NEED_REDUCE = (SIZE < SHIFT_SPAN);
  localparam logic [SHIFT_W-1:0] SIZE_S = NEED_REDUCE ? SHIFT_W'(SIZE) : '0;

  always_comb begin
    shift_in = s_shift;
    if (NEED_REDUCE && (s_shift >= SIZE_S))
      shift_in = s_shift - SIZE_S;
  end
`else
  assign shift_in = s_shift;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FILL;
      idx_reg   <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (accept) begin
            if (idx_reg == '0)
              shift_reg <= shift_in;
            if (s_last || last_lane) begin
              state_reg <= FULL;
              valid_reg <= 1'b1;
              idx_reg   <= '0;
              // Length is wrong whenever s_last and the final lane disagree.
              if (s_last != last_lane)
                err_reg <= 1'b1;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        FULL: begin
          if (consume) begin
            state_reg <= FILL;
            valid_reg <= 1'b0;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
      logic [WIDTH-1:0] lane_reg;

      always_ff @(posedge clk) begin
        if (rst || consume)
          lane_reg <= '0;
        else if (accept && (idx_reg == IDX_W'(gi)))
          lane_reg <= s_data;
      end

      assign out_list[gi*WIDTH +: WIDTH] = lane_reg;
    end
  endgenerate

  assign out_shift = shift_reg;
  assign out_valid = valid_reg;
  assign err_len   = err_reg;

endmodule

// File: tb/tb_coeff_vector_loader.sv
// Directed bench for coeff_vector_loader: a full-size instance and a SIZE=5 instance side by side.
module tb_coeff_vector_loader;

  localparam int W   = 32;
  localparam int SA  = 257;
  localparam int SWA = 9;
  localparam int SB  = 5;
  localparam int SWB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Full-size instance
  logic              a_rst, a_s_last, a_s_valid, a_s_ready, a_out_valid, a_out_ready, a_err;
  logic [W-1:0]      a_s_data;
  logic [SWA-1:0]    a_s_shift, a_out_shift;
  logic [SA*W-1:0]   a_out_list;

  // SIZE=5 instance
  logic              b_rst, b_s_last, b_s_valid, b_s_ready, b_out_valid, b_out_ready, b_err;
  logic [W-1:0]      b_s_data;
  logic [SWB-1:0]    b_s_shift, b_out_shift;
  logic [SB*W-1:0]   b_out_list;

  coeff_vector_loader #(.WIDTH(W), .SIZE(SA), .SHIFT_W(SWA)) dut_a (
    .clk(clk), .rst(a_rst), .s_data(a_s_data), .s_shift(a_s_shift), .s_last(a_s_last),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .out_list(a_out_list), .out_shift(a_out_shift),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .err_len(a_err)
  );

  coeff_vector_loader #(.WIDTH(W), .SIZE(SB), .SHIFT_W(SWB)) dut_b (
    .clk(clk), .rst(b_rst), .s_data(b_s_data), .s_shift(b_s_shift), .s_last(b_s_last),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .out_list(b_out_list), .out_shift(b_out_shift),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .err_len(b_err)
  );

  logic [SA*W-1:0] exp_a;
  logic [SB*W-1:0] exp_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic consume_a();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic consume_b();
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_s_valid = 1'b1; a_s_data = 32'hDEAD; a_s_shift = 9'd3; a_s_last = 1'b1; a_out_ready = 1'b0;
    b_s_valid = 1'b1; b_s_data = 32'hBEEF; b_s_shift = 3'd2; b_s_last = 1'b1; b_out_ready = 1'b0;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;
    a_s_valid = 1'b0; b_s_valid = 1'b0;
    a_s_last = 1'b0; b_s_last = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got=%b want=0", a_out_valid); end
    checks++; if (a_out_list !== '0) begin errors++; $display("FAIL reset_a_list got nonzero want=0"); end
    checks++; if (a_out_shift !== '0) begin errors++; $display("FAIL reset_a_shift got=%0d want=0", a_out_shift); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_a_err got=%b want=0", a_err); end
    checks++; if (a_s_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready got=%b want=1", a_s_ready); end
    checks++; if ({b_out_valid, b_err, b_s_ready} !== 3'b001 || b_out_list !== '0)
      begin errors++; $display("FAIL reset_b got valid/err/ready=%b%b%b want=001", b_out_valid, b_err, b_s_ready); end
    $display("reset: done");
  endtask

  task automatic test_full_frame();
    int not_ready = 0;
    int bad = 0;
    logic early_valid = 1'b0;
    for (int i = 0; i < SA; i++) begin
      if (a_s_ready !== 1'b1) not_ready++;
      if (a_out_valid !== 1'b0) early_valid = 1'b1;
      a_s_valid = 1'b1;
      a_s_data  = 32'(i + 1);
      a_s_shift = (i == 0) ? 9'd5 : 9'h1FF;
      a_s_last  = (i == SA - 1);
      tick();
    end
    a_s_valid = 1'b0; a_s_last = 1'b0;
    checks++; if (not_ready != 0) begin errors++; $display("FAIL full_ready_during_fill got=%0d stalls want=0", not_ready); end
    checks++; if (early_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got=1 want=0"); end
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%b want=1", a_out_valid); end
    for (int i = 0; i < SA; i++)
      if (a_out_list[i*W +: W] !== 32'(i + 1)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL full_lanes got=%0d bad lanes want=0", bad); end
    checks++; if (a_out_shift !== 9'd5) begin errors++; $display("FAIL full_shift got=%0d want=5", a_out_shift); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL full_err got=%b want=0", a_err); end
    checks++; if (a_s_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b want=0", a_s_ready); end
    $display("full_frame: 257 beats, out_shift=%0d", a_out_shift);
  endtask

  task automatic test_hold_consume();
    int unstable = 0;
    for (int i = 0; i < SA; i++) exp_a[i*W +: W] = 32'(i + 1);
    // Beats offered while FULL must be ignored.
    a_s_valid = 1'b1; a_s_data = 32'h5555_AAAA; a_s_shift = 9'd77; a_s_last = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (a_out_list !== exp_a || a_out_shift !== 9'd5 || a_out_valid !== 1'b1 || a_s_ready !== 1'b0)
        unstable++;
    end
    a_s_valid = 1'b0; a_s_last = 1'b0;
    checks++; if (unstable != 0) begin errors++; $display("FAIL hold_stable got=%0d unstable cycles want=0", unstable); end
    consume_a();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL consume_valid got=%b want=0", a_out_valid); end
    checks++; if (a_s_ready !== 1'b1) begin errors++; $display("FAIL consume_ready got=%b want=1", a_s_ready); end
    checks++; if (a_out_list !== '0) begin errors++; $display("FAIL consume_list got nonzero want=0"); end
    checks++; if (a_out_shift !== 9'd5) begin errors++; $display("FAIL consume_shift got=%0d want=5", a_out_shift); end
    $display("hold_consume: 20 held cycles then consumed");
  endtask

  task automatic test_early_last();
    logic [W-1:0] d [3] = '{32'd7, 32'd8, 32'd9};
    for (int i = 0; i < 3; i++) begin
      b_s_valid = 1'b1; b_s_data = d[i]; b_s_shift = (i == 0) ? 3'd2 : 3'd7; b_s_last = (i == 2);
      tick();
    end
    b_s_valid = 1'b0; b_s_last = 1'b0;
    exp_b = {32'd0, 32'd0, 32'd9, 32'd8, 32'd7};
    checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL early_valid got=%b want=1", b_out_valid); end
    checks++; if (b_out_list !== exp_b) begin errors++; $display("FAIL early_list got=%h want=%h", b_out_list, exp_b); end
    checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL early_err got=%b want=1", b_err); end
    checks++; if (b_out_shift !== 3'd2) begin errors++; $display("FAIL early_shift got=%0d want=2", b_out_shift); end
    consume_b();
    for (int i = 0; i < SB; i++) begin
      b_s_valid = 1'b1; b_s_data = 32'(i + 1); b_s_shift = (i == 0) ? 3'd1 : 3'd4; b_s_last = (i == SB - 1);
      tick();
    end
    b_s_valid = 1'b0; b_s_last = 1'b0;
    exp_b = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    checks++; if (b_out_list !== exp_b) begin errors++; $display("FAIL clean_list got=%h want=%h", b_out_list, exp_b); end
    checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", b_err); end
    checks++; if (b_out_shift !== 3'd1) begin errors++; $display("FAIL clean_shift got=%0d want=1", b_out_shift); end
    consume_b();
    $display("early_last: lanes {7,8,9,0,0} then clean frame");
  endtask

  task automatic test_overflow();
    logic [SWB-1:0] exp_s;
    b_rst = 1'b1; tick(); b_rst = 1'b0;
    for (int i = 0; i < SB; i++) begin
      b_s_valid = 1'b1; b_s_data = 32'(11 + i); b_s_shift = (i == 0) ? 3'd3 : 3'd0; b_s_last = 1'b0;
      tick();
    end
    exp_b = {32'd15, 32'd14, 32'd13, 32'd12, 32'd11};
    checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b want=1", b_out_valid); end
    checks++; if (b_out_list !== exp_b) begin errors++; $display("FAIL ovf_list got=%h want=%h", b_out_list, exp_b); end
    checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b want=1", b_err); end
    // Sixth beat waits through the consume edge, then opens the next frame.
    b_s_valid = 1'b1; b_s_data = 32'd16; b_s_shift = 3'd6; b_s_last = 1'b1;
    consume_b();
    tick();
    b_s_valid = 1'b0; b_s_last = 1'b0;
`ifdef SHIFT_REDUCE_EN
    exp_s = 3'd1;
`else
    exp_s = 3'd6;
`endif
    exp_b = {32'd0, 32'd0, 32'd0, 32'd0, 32'd16};
    checks++; if (b_out_list !== exp_b) begin errors++; $display("FAIL ovf_next_list got=%h want=%h", b_out_list, exp_b); end
    checks++; if (b_out_shift !== exp_s) begin errors++; $display("FAIL ovf_next_shift got=%0d want=%0d", b_out_shift, exp_s); end
    consume_b();
    $display("overflow: 6 beats split 5+1");
  endtask

  task automatic test_reset_midframe();
    a_s_valid = 1'b1; a_s_data = 32'd1; a_s_shift = 9'd1; a_s_last = 1'b1;
    tick();
    a_s_valid = 1'b0; a_s_last = 1'b0;
    consume_a();
    for (int i = 0; i <= 100; i++) begin
      a_s_valid = 1'b1; a_s_data = 32'(1000 + i); a_s_shift = 9'd9; a_s_last = 1'b0;
      a_rst = (i == 100);
      tick();
    end
    a_rst = 1'b0; a_s_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", a_out_valid); end
    checks++; if (a_out_list !== '0) begin errors++; $display("FAIL midrst_list got nonzero want=0"); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b want=0", a_err); end
    checks++; if (a_s_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", a_s_ready); end
    a_s_valid = 1'b1; a_s_data = 32'h0000_ABCD; a_s_shift = 9'd7; a_s_last = 1'b1;
    tick();
    a_s_valid = 1'b0; a_s_last = 1'b0;
    exp_a = '0; exp_a[W-1:0] = 32'h0000_ABCD;
    checks++; if (a_out_list !== exp_a) begin errors++; $display("FAIL midrst_lane0 got=%h want=0000abcd", a_out_list[W-1:0]); end
    checks++; if (a_out_shift !== 9'd7) begin errors++; $display("FAIL midrst_shift got=%0d want=7", a_out_shift); end
    consume_a();
    $display("reset_midframe: partial frame discarded");
  endtask

  task automatic test_shift_reduce();
    logic [SWA-1:0] exp_s;
`ifdef SHIFT_REDUCE_EN
    exp_s = 9'd43;
`else
    exp_s = 9'd300;
`endif
    a_s_valid = 1'b1; a_s_data = 32'd2; a_s_shift = 9'd300; a_s_last = 1'b1;
    tick();
    a_s_valid = 1'b0; a_s_last = 1'b0;
    checks++; if (a_out_shift !== exp_s) begin errors++; $display("FAIL shift300 got=%0d want=%0d", a_out_shift, exp_s); end
    consume_a();
    a_s_valid = 1'b1; a_s_data = 32'd3; a_s_shift = 9'd256; a_s_last = 1'b1;
    tick();
    a_s_valid = 1'b0; a_s_last = 1'b0;
    checks++; if (a_out_shift !== 9'd256) begin errors++; $display("FAIL shift256 got=%0d want=256", a_out_shift); end
    consume_a();
    $display("shift_reduce: 300 -> %0d, 256 -> 256", exp_s);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_hold_consume();
    test_early_last();
    test_overflow();
    test_reset_midframe();
    test_shift_reduce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
